cix32_simd_sched: RTL and testbench

//  Issue scheduler for the CIX-32 SIMD/MMX/SSE execution unit. Arbitrates SIMD ops from two decode

---
 rtl/cix32_simd_pkg.sv | 57 +++++
 rtl/cix32_simd_opq.sv | 51 +++++
 rtl/cix32_simd_sched.sv | 126 ++++++++++++
 tb/tb_cix32_simd_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cix32_simd_pkg.sv
// rtl/cix32_simd_pkg.sv - shared types for the CIX-32 SIMD issue scheduler
package cix32_simd_pkg;

  localparam int SIMD_OP_W = 5;

  typedef enum logic [SIMD_OP_W-1:0] {
    PADDB  = 5'h00,
    PADDW  = 5'h01,
    PADDD  = 5'h02,
    PSUBB  = 5'h03,
    PSUBW  = 5'h04,
    PMULLW = 5'h05,
    PAND   = 5'h06,
    POR    = 5'h07,
    PXOR   = 5'h08,
    ADDPS  = 5'h09,
    SUBPS  = 5'h0a,
    MULPS  = 5'h0b,
    DIVPS  = 5'h0c,
    MAXPS  = 5'h0d,
    MINPS  = 5'h0e,
    CMPPS  = 5'h0f
  } simd_op_t;

  typedef enum logic [2:0] {
    MODE_MMX  = 3'd0,
    MODE_SSE  = 3'd1,
    MODE_SSE2 = 3'd2,
    MODE_SSE3 = 3'd3
  } simd_mode_t;

  typedef struct packed {
    simd_op_t   op;
    simd_mode_t mode;
    logic [2:0] src;
    logic [2:0] dst;
  } simd_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } sched_state_t;

  function automatic simd_req_t make_req(input logic [SIMD_OP_W-1:0] op,
                                         input logic [2:0] mode,
                                         input logic [2:0] src,
                                         input logic [2:0] dst);
    simd_req_t r;
    r.op   = simd_op_t'(op);
    r.mode = simd_mode_t'(mode);
    r.src  = src;
    r.dst  = dst;
    return r;
  endfunction

endpackage

// File: rtl/cix32_simd_opq.sv
// rtl/cix32_simd_opq.sv - in-order op queue, two write ports (port 0 first) and one read port
module cix32_simd_opq
  import cix32_simd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [1:0]               wr_en,
  input  simd_req_t                wr_data0,
  input  simd_req_t                wr_data1,
  input  logic                     rd_en,
  output simd_req_t                rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  simd_req_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  n_wr;
  logic [AW-1:0]  wr_ptr1;

  assign n_wr    = CW'(wr_en[0]) + CW'(wr_en[1]);
  assign wr_ptr1 = wr_en[0] ? wr_ptr + AW'(1) : wr_ptr;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      if (wr_en[0]) mem[wr_ptr] <= wr_data0;
      if (wr_en[1]) mem[wr_ptr1] <= wr_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_wr);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + n_wr - CW'(rd_en);
    end
  end

endmodule

// File: rtl/cix32_simd_sched.sv
// rtl/cix32_simd_sched.sv - U/V round-robin issue scheduler for the non-pipelined SIMD unit
module cix32_simd_sched
  import cix32_simd_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 64,
  parameter int OP_W    = SIMD_OP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*OP_W-1:0]         req_op,
  input  logic [5:0]                req_mode,
  input  logic [5:0]                req_src,
  input  logic [5:0]                req_dst,
  input  logic                      flush,
  output logic                      unit_start,
  output logic [OP_W-1:0]           unit_op,
  output logic [2:0]                unit_mode,
  output logic [2:0]                unit_src,
  output logic [2:0]                unit_dst,
  input  logic                      unit_busy,
  input  logic                      unit_done,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      sched_fault
);

  localparam int CW   = $clog2(QDEPTH) + 1;
  localparam int WD_W = $clog2(TIMEOUT);

  sched_state_t    state;
  logic [WD_W-1:0] wd_cnt;
  logic            rr;
  logic [1:0]      grant;
  logic            launch;
  simd_req_t       req_u;
  simd_req_t       req_v;
  simd_req_t       head;

  assign req_u = make_req(req_op[OP_W-1:0], req_mode[2:0], req_src[2:0], req_dst[2:0]);
  assign req_v = make_req(req_op[2*OP_W-1:OP_W], req_mode[5:3], req_src[5:3], req_dst[5:3]);

  // Ready looks only at registered occupancy; the same-cycle pop is not credited.
  always_comb begin
    req_ready = 2'b00;
    if (!rst && !flush) begin
      if (q_count <= CW'(QDEPTH - 2))
        req_ready = 2'b11;
      else if (q_count == CW'(QDEPTH - 1))
        req_ready = rr ? 2'b10 : 2'b01;
    end
  end

  assign grant  = req_valid & req_ready;
  assign launch = (state == IDLE) && (q_count != '0) && !unit_busy && !sched_fault && !flush;

  cix32_simd_opq #(.DEPTH(QDEPTH)) u_opq (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .wr_en    (grant),
    .wr_data0 (req_u),
    .wr_data1 (req_v),
    .rd_en    (launch),
    .rd_data  (head),
    .count    (q_count)
  );

  // Pointer only moves on a contested single grant; it then favours the loser.
  always_ff @(posedge clk) begin
    if (rst)
      rr <= 1'b0;
    else if (grant == 2'b01 && req_valid[1])
      rr <= 1'b1;
    else if (grant == 2'b10 && req_valid[0])
      rr <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      sched_fault <= 1'b0;
      unit_start  <= 1'b0;
      unit_op     <= '0;
      unit_mode   <= '0;
      unit_src    <= '0;
      unit_dst    <= '0;
    end else begin
      unit_start <= 1'b0;
      if (flush) begin
        state       <= IDLE;
        wd_cnt      <= '0;
        sched_fault <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (launch) begin
              state      <= WAIT;
              wd_cnt     <= '0;
              unit_start <= 1'b1;
              unit_op    <= OP_W'(head.op);
              unit_mode  <= head.mode;
              unit_src   <= head.src;
              unit_dst   <= head.dst;
            end
          end
          WAIT: begin
            if (unit_done) begin
              state <= IDLE;
            end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
              sched_fault <= 1'b1;
              state       <= FAULT;
            end else begin
              wd_cnt <= wd_cnt + WD_W'(1);
            end
          end
          FAULT:   state <= FAULT;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cix32_simd_sched.sv
// tb/tb_cix32_simd_sched.sv - directed self-checking bench for cix32_simd_sched
module tb_cix32_simd_sched;
  import cix32_simd_pkg::*;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst, flush, unit_busy, force_done, unit_done;
  logic       resp_done = 1'b0;
  logic [1:0] req_valid, req_ready;
  logic [9:0] req_op;
  logic [5:0] req_mode, req_src, req_dst;
  logic       unit_start, sched_fault;
  logic [4:0] unit_op;
  logic [2:0] unit_mode, unit_src, unit_dst;
  logic [2:0] q_count;

  int errs = 0, n_checks = 0;
  int done_lat = 0, cd = 0, n_start = 0, n0 = 0;
  int uid, vid, qmax, n_single, seq;
  logic [1:0] g;
  logic [4:0] launched[$];
  logic [4:0] exp_order[8];

  always #5 clk = ~clk;

  assign unit_done = resp_done | force_done;

  cix32_simd_sched #(.QDEPTH(4), .TIMEOUT(TIMEOUT), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_mode(req_mode), .req_src(req_src), .req_dst(req_dst),
    .flush(flush), .unit_start(unit_start), .unit_op(unit_op), .unit_mode(unit_mode),
    .unit_src(unit_src), .unit_dst(unit_dst), .unit_busy(unit_busy), .unit_done(unit_done),
    .q_count(q_count), .sched_fault(sched_fault)
  );

  // SIMD unit model: logs every launch, pulses done done_lat cycles after start (0 = never)
  initial forever begin
    @(posedge clk); #1;
    resp_done = 1'b0;
    if (unit_start) begin
      n_start++;
      launched.push_back(unit_op);
      cd = done_lat;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) resp_done = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_start(input int max_cyc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      seen = unit_start;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic set_u(input logic [4:0] op, input logic [2:0] mode, input logic [2:0] src, input logic [2:0] dst);
    req_op[4:0] = op; req_mode[2:0] = mode; req_src[2:0] = src; req_dst[2:0] = dst;
  endtask

  task automatic set_v(input logic [4:0] op, input logic [2:0] mode, input logic [2:0] src, input logic [2:0] dst);
    req_op[9:5] = op; req_mode[5:3] = mode; req_src[5:3] = src; req_dst[5:3] = dst;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; unit_busy = 1'b0; force_done = 1'b0;
    req_valid = 2'b00; req_op = '0; req_mode = '0; req_src = '0; req_dst = '0;
    exp_order = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
    step(); step();
    check("rst_start", 32'(unit_start), 32'd0);
    check("rst_qcount", 32'(q_count), 32'd0);
    check("rst_fault", 32'(sched_fault), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_op", 32'(unit_op), 32'd0);
    rst = 1'b0;

    // 1: single U op, done 3 cycles after start
    done_lat = 3;
    set_u(PADDB, 3'd0, 3'd1, 3'd2);
    req_valid = 2'b01;
    #1;
    check("t1_ready", 32'(req_ready), 32'd3);
    step(); req_valid = 2'b00;
    check("t1_q1", 32'(q_count), 32'd1);
    check("t1_nostart", 32'(unit_start), 32'd0);
    step();
    check("t1_start", 32'(unit_start), 32'd1);
    check("t1_op", 32'(unit_op), 32'd0);
    check("t1_src", 32'(unit_src), 32'd1);
    check("t1_dst", 32'(unit_dst), 32'd2);
    check("t1_q0", 32'(q_count), 32'd0);
    step(); step(); step();
    check("t1_wait", 32'(dut.state), 32'(WAIT));
    check("t1_hold_dst", 32'(unit_dst), 32'd2);
    step();
    check("t1_idle", 32'(dut.state), 32'(IDLE));

    // 2: both ports every cycle, slow unit
    launched.delete();
    done_lat = 10;
    uid = 1; vid = 9; qmax = 0; n_single = 0; seq = 0;
    set_u(5'd0, 3'd0, 3'd0, 3'd0); set_v(5'd0, 3'd1, 3'd0, 3'd0);
    for (int c = 0; c < 27; c++) begin
      req_valid = 2'b11;
      req_op = {vid[4:0], uid[4:0]};
      #1;
      g = req_ready & req_valid;
      if (g == 2'b01 || g == 2'b10) begin
        n_single++;
        seq = (seq << 1) | int'(g[1]);
      end
      step();
      if (g[0]) uid++;
      if (g[1]) vid++;
      if (int'(q_count) > qmax) qmax = int'(q_count);
      if (c == 2) check("t2_qfull", 32'(q_count), 32'd4);
    end
    req_valid = 2'b00;
    check("t2_qmax", 32'(qmax), 32'd4);
    check("t2_nsingle", 32'(n_single), 32'd3);
    check("t2_alt_uvu", 32'(seq), 32'b010);
    check("t2_nlaunch", 32'(launched.size()), 32'd3);

    // 3: enqueue and launch on the same edge keeps occupancy unchanged
    done_lat = 1;
    wait_start(20, "t3_start_op10");
    check("t3_op10", 32'(unit_op), 32'd10);
    step(); step();
    req_valid = 2'b10;
    req_op[9:5] = vid[4:0];
    #1;
    check("t3_ready_v", 32'(req_ready), 32'd2);
    step(); req_valid = 2'b00;
    check("t3_qsame", 32'(q_count), 32'd3);
    check("t3_start", 32'(unit_start), 32'd1);
    check("t3_op3", 32'(unit_op), 32'd3);
    wait_start(6, "t3_drain1");
    wait_start(6, "t3_drain2");
    wait_start(6, "t3_drain3");
    step(); step(); step();
    check("t3_empty", 32'(q_count), 32'd0);
    check("t3_nlaunch", 32'(launched.size()), 32'd8);
    for (int i = 0; i < 8 && i < launched.size(); i++)
      check($sformatf("t3_order%0d", i), 32'(launched[i]), 32'(exp_order[i]));

    // 4: watchdog fault and flush recovery
    done_lat = 0;
    set_u(PMULLW, 3'd1, 3'd0, 3'd5);
    req_valid = 2'b01; step(); req_valid = 2'b00;
    wait_start(5, "t4_start");
    n0 = n_start;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("t4_nofault_early", 32'(sched_fault), 32'd0);
    step();
    check("t4_fault", 32'(sched_fault), 32'd1);
    check("t4_state", 32'(dut.state), 32'(FAULT));
    req_valid = 2'b11; step(); req_valid = 2'b00;
    step(); step(); step(); step();
    check("t4_q_in_fault", 32'(q_count), 32'd2);
    check("t4_no_launch", 32'(n_start - n0), 32'd0);
    flush = 1'b1; req_valid = 2'b11;
    #1;
    check("t4_flush_ready", 32'(req_ready), 32'd0);
    step(); flush = 1'b0; req_valid = 2'b00;
    check("t4_fault_clr", 32'(sched_fault), 32'd0);
    check("t4_q_clr", 32'(q_count), 32'd0);
    check("t4_idle", 32'(dut.state), 32'(IDLE));

    // 5: flush together with unit_done and valid requests
    set_u(5'd6, 3'd0, 3'd2, 3'd3);
    req_valid = 2'b01; step(); req_valid = 2'b00;
    wait_start(5, "t5_start");
    set_u(5'd7, 3'd0, 3'd2, 3'd3);
    req_valid = 2'b01; step();
    req_valid = 2'b11; flush = 1'b1; force_done = 1'b1;
    #1;
    check("t5_ready", 32'(req_ready), 32'd0);
    step(); flush = 1'b0; force_done = 1'b0; req_valid = 2'b00;
    check("t5_q", 32'(q_count), 32'd0);
    check("t5_idle", 32'(dut.state), 32'(IDLE));
    check("t5_start", 32'(unit_start), 32'd0);
    n0 = n_start;
    step(); step(); step();
    check("t5_no_launch", 32'(n_start - n0), 32'd0);

    // 6: reset while waiting with three ops queued
    set_u(5'd1, 3'd0, 3'd1, 3'd1); set_v(5'd2, 3'd1, 3'd2, 3'd2);
    req_valid = 2'b11; step(); step(); req_valid = 2'b00;
    check("t6_q3", 32'(q_count), 32'd3);
    check("t6_start", 32'(unit_start), 32'd1);
    rst = 1'b1; req_valid = 2'b11;
    #1;
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    step();
    check("t6_rst_start", 32'(unit_start), 32'd0);
    check("t6_rst_q", 32'(q_count), 32'd0);
    check("t6_rst_fault", 32'(sched_fault), 32'd0);
    check("t6_rst_fields", 32'({unit_op, unit_mode, unit_src, unit_dst}), 32'd0);
    rst = 1'b0; req_valid = 2'b00; force_done = 1'b1;
    step(); force_done = 1'b0;
    check("t6_spurious_idle", 32'(dut.state), 32'(IDLE));
    check("t6_spurious_q", 32'(q_count), 32'd0);
    check("t6_spurious_start", 32'(unit_start), 32'd0);
    done_lat = 2;
    set_u(5'd8, 3'd2, 3'd3, 3'd4);
    req_valid = 2'b01; step(); req_valid = 2'b00;
    wait_start(5, "t6_relaunch");
    check("t6_op", 32'(unit_op), 32'd8);
    check("t6_mode", 32'(unit_mode), 32'd2);
    check("t6_src", 32'(unit_src), 32'd3);
    check("t6_dst", 32'(unit_dst), 32'd4);
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errs, n_checks);
    $finish;
  end

endmodule
